clkdiv_ctrl: RTL and testbench

//  Run-time controller for the divided-clock datapath. It starts and stops the divided output

---
 rtl/clkdiv_ctrl.sv | 144 ++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// Run-time divided-clock controller: glitch-free start/stop and ratio changes that are
// applied only at period boundaries, so clk_out never produces a runt pulse.
module clkdiv_ctrl #(
  parameter int          CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 32'd10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0] DIV_RST  = DIV_DEFAULT[CNT_W-1:0];

  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] d_act_r, d_act_s;
  logic [CNT_W-1:0] pend_r, pend_s;
  logic             pend_full_r, pend_full_s;
  logic             err_s;
  logic             xfer_s;
  logic             boundary_s;
  logic             run_s;
  logic [CNT_W-1:0] cnt_adv_s;
  logic             clk_out_r, tick_r, cfg_err_r, busy_r, cfg_ready_r;

  assign xfer_s     = cfg_valid && !pend_full_r;
  assign boundary_s = (cnt_r == (d_act_r - CNT_ONE));
  assign cnt_adv_s  = boundary_s ? CNT_ZERO : (cnt_r + CNT_ONE);

  // Next-state, counter, ratio and pending-config logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    d_act_s     = d_act_r;
    pend_s      = pend_r;
    pend_full_s = pend_full_r;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (start && !stop) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_s = cnt_adv_s;
        if (stop) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STOP: begin
        cnt_s = cnt_adv_s;
        if (start) begin
          state_s = ST_RUN;
        end else if (boundary_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    // A held ratio swaps in exactly when the counter wraps, including on the way to IDLE.
    if ((state_r != ST_IDLE) && boundary_s && pend_full_r) begin
      d_act_s     = pend_r;
      pend_full_s = 1'b0;
    end else begin
      pend_full_s = pend_full_s;
    end

    if (xfer_s) begin
      if (cfg_div < CNT_TWO) begin
        err_s = 1'b1;
      end else if (state_r == ST_IDLE) begin
        d_act_s = cfg_div;
      end else begin
        pend_s      = cfg_div;
        pend_full_s = 1'b1;
      end
    end else begin
      err_s = 1'b0;
    end
  end

  assign run_s = (state_s != ST_IDLE);

  // State and registered outputs, computed from next-state so outputs align with cnt.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      d_act_r     <= DIV_RST;
      pend_r      <= CNT_ZERO;
      pend_full_r <= 1'b0;
      clk_out_r   <= 1'b0;
      tick_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      d_act_r     <= d_act_s;
      pend_r      <= pend_s;
      pend_full_r <= pend_full_s;
      clk_out_r   <= run_s && (cnt_s < (d_act_s >> 1));
      tick_r      <= run_s && (cnt_s == CNT_ZERO);
      cfg_err_r   <= err_s;
      busy_r      <= run_s;
      cfg_ready_r <= !pend_full_s;
    end
  end

  assign clk_out   = clk_out_r;
  assign tick      = tick_r;
  assign cfg_err   = cfg_err_r;
  assign busy      = busy_r;
  assign cfg_ready = cfg_ready_r;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: start/stop, ratio changes, bad ratios and reset.
module tb_clkdiv_ctrl;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic        stop;
  logic [15:0] cfg_div;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_err;
  logic        clk_out;
  logic        tick;
  logic        busy;

  int passed = 0;
  int total  = 0;

  clkdiv_ctrl #(.CNT_W(16), .DIV_DEFAULT(10)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .stop      (stop),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int k = 0; k < limit; k++) begin
      if (busy === 1'b0) break;
      step();
    end
    chk("wait_idle_timeout", busy, 1'b0);
  endtask

  initial begin
    sys_rst   = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_div   = 16'd0;
    cfg_valid = 1'b0;
    step();
    sys_rst = 1'b0;

    // 1: reset state, then default D=10
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("d10_clk", clk_out, (i % 10) < 5);
      chk("d10_tick", tick, (i % 10) == 0);
      chk("d10_busy", busy, 1'b1);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int j = 1; j < 10; j++) begin
      chk("d10_stopping_clk", clk_out, j < 5);
      chk("d10_stopping_busy", busy, 1'b1);
      step();
    end
    chk("d10_idle_busy", busy, 1'b0);
    chk("d10_idle_clk", clk_out, 1'b0);

    // 2: load D=4 in IDLE
    cfg_div   = 16'd4;
    cfg_valid = 1'b1;
    chk("idle_cfg_ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    chk("idle_cfg_ready_after", cfg_ready, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("d4_clk", clk_out, (i % 4) < 2);
      chk("d4_tick", tick, (i % 4) == 0);
      step();
    end

    // 3: D=4 -> D=5 requested at cnt=1
    step();
    cfg_div   = 16'd5;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("d4to5_cnt2_clk", clk_out, 1'b0);
    chk("d4to5_cnt2_ready", cfg_ready, 1'b0);
    step();
    chk("d4to5_cnt3_clk", clk_out, 1'b0);
    chk("d4to5_cnt3_ready", cfg_ready, 1'b0);
    step();
    chk("d5_first_tick", tick, 1'b1);
    chk("d5_ready_back", cfg_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("d5_clk", clk_out, (i % 5) < 2);
      chk("d5_tick", tick, (i % 5) == 0);
      step();
    end

    // 4: switch to D=6, stop at cnt=1
    cfg_div   = 16'd6;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("d5to6_ready_low", cfg_ready, 1'b0);
    step();
    step();
    step();
    step();
    chk("d6_first_clk", clk_out, 1'b1);
    chk("d6_first_tick", tick, 1'b1);
    chk("d6_ready_back", cfg_ready, 1'b1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int j = 2; j < 6; j++) begin
      chk("d6_stopping_clk", clk_out, j < 3);
      chk("d6_stopping_busy", busy, 1'b1);
      step();
    end
    chk("d6_idle_busy", busy, 1'b0);
    chk("d6_idle_clk", clk_out, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("d6_resume_cnt5_clk", clk_out, 1'b0);
    chk("d6_resume_cnt5_busy", busy, 1'b1);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("d6_resume_clk", clk_out, (i % 6) < 3);
      chk("d6_resume_tick", tick, (i % 6) == 0);
      chk("d6_resume_busy", busy, 1'b1);
      step();
    end
    chk("d6_resume_next_tick", tick, 1'b1);
    chk("d6_resume_next_busy", busy, 1'b1);

    // 5: illegal ratios and start+stop in IDLE
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(20);
    cfg_div   = 16'd1;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("err_div1_pulse", cfg_err, 1'b1);
    chk("err_div1_ready", cfg_ready, 1'b1);
    step();
    chk("err_div1_clear", cfg_err, 1'b0);
    cfg_div   = 16'd0;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("err_div0_pulse", cfg_err, 1'b1);
    step();
    chk("err_div0_clear", cfg_err, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", busy, 1'b0);
    chk("startstop_clk", clk_out, 1'b0);
    step();
    chk("startstop_busy_later", busy, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("d6_kept_clk", clk_out, (i % 6) < 3);
      chk("d6_kept_tick", tick, (i % 6) == 0);
      step();
    end
    chk("d6_kept_wrap_tick", tick, 1'b1);

    // 6: reset in a high phase with a pending ratio
    cfg_div   = 16'd3;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("rst_mid_pre_clk", clk_out, 1'b1);
    chk("rst_mid_pre_ready", cfg_ready, 1'b0);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("rst_mid_clk", clk_out, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_tick", tick, 1'b0);
    chk("rst_mid_ready", cfg_ready, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_mid_d10_clk", clk_out, (i % 10) < 5);
      chk("rst_mid_d10_tick", tick, (i % 10) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
